trace_capture: RTL and testbench

- Synthesizable retire-event trace buffer for the multi-cycle MIPS core; it moves the PC/INSTR/writeback visibility and the fixed run-length of the bench into hardware.
- Records one entry per retired instruction into a circular buffer. Supports a PC-match trigger with a programmable post-trigger window and a no-retire watchdog.
- After capture the buffer freezes and is read out oldest-first through a pop handshake.
- Sits beside `mips`, fed from its writeback/commit signals.

---
 rtl/trace_capture.sv | 187 ++++++++++++++++++
 tb/tb_trace_capture.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - retire-event trace buffer with PC trigger, post window and idle watchdog
//
// Records one 102-bit entry per retired instruction into a circular buffer.
// Capture starts on arm and ends on one of two conditions: a PC-match trigger
// followed by POST_TRIG further stores, or TIMEOUT consecutive cycles with no
// retire. The frozen buffer is then drained oldest-first with a show-ahead
// pop interface.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   ev_*                retire event from the core (valid, pc, instr, GPR write)
//   arm                 clear the buffer and start capture (any state)
//   trig_en, trig_pc    PC-match trigger
//   rd_en               pop the head entry (DONE only)
//   rd_*                head entry, forced to 0 while rd_valid=0
//   state               IDLE=0, ARMED=1, POST=2, DONE=3
//   count               stored entries, 0..DEPTH
//   done                state==DONE
//   timeout, overflow   sticky: watchdog ended capture / an entry was overwritten
module trace_capture #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int POST_TRIG = 8,
  parameter int TIMEOUT   = 300
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ev_valid,
  input  logic [31:0]       ev_pc,
  input  logic [31:0]       ev_instr,
  input  logic              ev_wr_en,
  input  logic [4:0]        ev_wr_addr,
  input  logic [31:0]       ev_wr_data,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [31:0]       trig_pc,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [31:0]       rd_pc,
  output logic [31:0]       rd_instr,
  output logic              rd_wr_en,
  output logic [4:0]        rd_wr_addr,
  output logic [31:0]       rd_wr_data,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              timeout,
  output logic              overflow
);

  localparam int CNT_W   = ADDR_W + 1;
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  // A zero-length post window still needs a legal (unused) counter width.
  localparam int POST_W  = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam int ENTRY_W = 102;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              cur_st, next_st;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [POST_W-1:0]   post_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  head;

  logic do_store, do_pop, do_trig, do_tmo;
  logic trig_hit;

  assign trig_hit = trig_en && (ev_pc == trig_pc);

  // Next-state and per-cycle action strobes; arm pre-empts everything else.
  always_comb begin
    next_st  = cur_st;
    do_store = 1'b0;
    do_pop   = 1'b0;
    do_trig  = 1'b0;
    do_tmo   = 1'b0;
    if (arm) begin
      next_st = ST_ARMED;
    end else begin
      case (cur_st)
        ST_ARMED, ST_POST: begin
          if (ev_valid) begin
            do_store = 1'b1;
            if (cur_st == ST_ARMED && trig_hit) begin
              do_trig = 1'b1;
              next_st = (POST_TRIG == 0) ? ST_DONE : ST_POST;
            end else if (cur_st == ST_POST && post_cnt == POST_W'(1)) begin
              next_st = ST_DONE;
            end
          end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
            // This idle cycle is the TIMEOUT-th in a row.
            do_tmo  = 1'b1;
            next_st = ST_DONE;
          end
        end
        ST_DONE: begin
          if (rd_en && count != '0) do_pop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_st   <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      idle_cnt <= '0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cur_st <= next_st;
      if (arm) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        post_cnt <= '0;
        idle_cnt <= '0;
        timeout  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (do_store) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (count == CNT_W'(DEPTH)) begin
            // Full: the new entry lands on the oldest slot, so the head moves on.
            rd_ptr   <= rd_ptr + ADDR_W'(1);
            overflow <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
          count  <= count - CNT_W'(1);
        end
        if (do_trig) begin
          post_cnt <= POST_W'(POST_TRIG);
        end else if (do_store && cur_st == ST_POST) begin
          post_cnt <= post_cnt - POST_W'(1);
        end
        if ((cur_st == ST_ARMED || cur_st == ST_POST) && !ev_valid && !do_tmo) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end else begin
          idle_cnt <= '0;
        end
        if (do_tmo) timeout <= 1'b1;
      end
    end
  end

  // Entry RAM carries no reset; it is only observed while count!=0.
  always_ff @(posedge clock) begin
    if (reset && do_store) begin
      mem[wr_ptr] <= {ev_pc, ev_instr, ev_wr_en, ev_wr_addr, ev_wr_data};
    end
  end

  assign head     = mem[rd_ptr];
  assign state    = cur_st;
  assign done     = (cur_st == ST_DONE);
  assign rd_valid = done && (count != '0);

  always_comb begin
    rd_pc      = '0;
    rd_instr   = '0;
    rd_wr_en   = 1'b0;
    rd_wr_addr = '0;
    rd_wr_data = '0;
    if (rd_valid) begin
      rd_pc      = head[101:70];
      rd_instr   = head[69:38];
      rd_wr_en   = head[37];
      rd_wr_addr = head[36:32];
      rd_wr_data = head[31:0];
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - self-checking bench for trace_capture (POST_TRIG=3 and POST_TRIG=0 instances)
module tb_trace_capture;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 20;
  localparam int AW      = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        ev_valid;
  logic [31:0] ev_pc;
  logic [31:0] ev_instr;
  logic        ev_wr_en;
  logic [4:0]  ev_wr_addr;
  logic [31:0] ev_wr_data;
  logic        arm;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        rd_en;

  logic        rd_valid_o   [2];
  logic [31:0] rd_pc_o      [2];
  logic [31:0] rd_instr_o   [2];
  logic        rd_wr_en_o   [2];
  logic [4:0]  rd_wr_addr_o [2];
  logic [31:0] rd_wr_data_o [2];
  logic [1:0]  state_o      [2];
  logic [AW:0] count_o      [2];
  logic        done_o       [2];
  logic        timeout_o    [2];
  logic        overflow_o   [2];

  always #5 clock = ~clock;

  // Instance 0: POST_TRIG=3. Instance 1: POST_TRIG=0. Both see the same stimulus.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    trace_capture #(
      .DEPTH(DEPTH),
      .POST_TRIG((g == 0) ? 3 : 0),
      .TIMEOUT(TIMEOUT)
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .ev_valid(ev_valid),
      .ev_pc(ev_pc),
      .ev_instr(ev_instr),
      .ev_wr_en(ev_wr_en),
      .ev_wr_addr(ev_wr_addr),
      .ev_wr_data(ev_wr_data),
      .arm(arm),
      .trig_en(trig_en),
      .trig_pc(trig_pc),
      .rd_en(rd_en),
      .rd_valid(rd_valid_o[g]),
      .rd_pc(rd_pc_o[g]),
      .rd_instr(rd_instr_o[g]),
      .rd_wr_en(rd_wr_en_o[g]),
      .rd_wr_addr(rd_wr_addr_o[g]),
      .rd_wr_data(rd_wr_data_o[g]),
      .state(state_o[g]),
      .count(count_o[g]),
      .done(done_o[g]),
      .timeout(timeout_o[g]),
      .overflow(overflow_o[g])
    );
  end

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Capture modelled as a bounded FIFO of entries plus a phase number.
  int   m_st   [2];
  int   m_left [2];
  int   m_idle [2];
  bit   m_tmo  [2];
  bit   m_ovf  [2];
  ent_t mq     [2][$];
  int   post_len [2] = '{3, 0};

  always @(posedge clock) begin
    ent_t e;
    e = '{ev_pc, ev_instr, ev_wr_en, ev_wr_addr, ev_wr_data};
    for (int i = 0; i < 2; i++) begin
      if (!reset || arm) begin
        m_st[i]  = reset ? 1 : 0;
        mq[i].delete();
        m_tmo[i] = 0; m_ovf[i] = 0; m_idle[i] = 0; m_left[i] = 0;
      end else if (m_st[i] == 1 || m_st[i] == 2) begin
        if (ev_valid) begin
          m_idle[i] = 0;
          mq[i].push_back(e);
          if (mq[i].size() > DEPTH) begin
            void'(mq[i].pop_front());
            m_ovf[i] = 1;
          end
          if (m_st[i] == 1 && trig_en && ev_pc == trig_pc) begin
            if (post_len[i] == 0) m_st[i] = 3;
            else begin m_left[i] = post_len[i]; m_st[i] = 2; end
          end else if (m_st[i] == 2) begin
            m_left[i]--;
            if (m_left[i] == 0) m_st[i] = 3;
          end
        end else begin
          m_idle[i]++;
          if (m_idle[i] == TIMEOUT) begin
            m_st[i] = 3; m_tmo[i] = 1; m_idle[i] = 0;
          end
        end
      end else if (m_st[i] == 3) begin
        if (rd_en && mq[i].size() > 0) void'(mq[i].pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        bit   v;
        ent_t h;
        v = (m_st[i] == 3) && (mq[i].size() > 0);
        h = v ? mq[i][0] : '0;
        check($sformatf("i%0d state", i),    64'(state_o[i]),      64'(m_st[i]));
        check($sformatf("i%0d count", i),    64'(count_o[i]),      64'(mq[i].size()));
        check($sformatf("i%0d done", i),     64'(done_o[i]),       64'(m_st[i] == 3));
        check($sformatf("i%0d timeout", i),  64'(timeout_o[i]),    64'(m_tmo[i]));
        check($sformatf("i%0d overflow", i), 64'(overflow_o[i]),   64'(m_ovf[i]));
        check($sformatf("i%0d rd_valid", i), 64'(rd_valid_o[i]),   64'(v));
        check($sformatf("i%0d rd_pc", i),    64'(rd_pc_o[i]),      64'(h.pc));
        check($sformatf("i%0d rd_instr", i), 64'(rd_instr_o[i]),   64'(h.instr));
        check($sformatf("i%0d rd_wr_en", i), 64'(rd_wr_en_o[i]),   64'(h.wr_en));
        check($sformatf("i%0d rd_waddr", i), 64'(rd_wr_addr_o[i]), 64'(h.wr_addr));
        check($sformatf("i%0d rd_wdata", i), 64'(rd_wr_data_o[i]), 64'(h.wr_data));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ev(input logic [31:0] pc);
    ev_valid   = 1'b1;
    ev_pc      = pc;
    ev_instr   = pc ^ 32'hA5A5_0000;
    ev_wr_en   = pc[2];
    ev_wr_addr = pc[6:2];
    ev_wr_data = ~pc;
  endtask

  task automatic send(input logic [31:0] pc);
    set_ev(pc);
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0; ev_valid = 1'b0; ev_pc = '0; ev_instr = '0; ev_wr_en = 1'b0;
    ev_wr_addr = '0; ev_wr_data = '0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_en = 1'b0;

    // 1. reset with random inputs
    tick();
    chk_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      arm = 1'($urandom); rd_en = 1'($urandom); trig_en = 1'($urandom);
      set_ev($urandom); ev_valid = 1'($urandom);
      tick();
    end
    check("rst state", 64'(state_o[0]), 64'd0);
    check("rst count", 64'(count_o[0]), 64'd0);
    check("rst rd_valid", 64'(rd_valid_o[0]), 64'd0);
    check("rst rd_pc", 64'(rd_pc_o[0]), 64'd0);
    check("rst timeout", 64'(timeout_o[0]), 64'd0);
    check("rst overflow", 64'(overflow_o[0]), 64'd0);
    arm = 1'b0; rd_en = 1'b0; ev_valid = 1'b0; trig_en = 1'b0;
    reset = 1'b1;
    send(32'h0000_1234);
    check("idle ignores ev", 64'(count_o[0]), 64'd0);

    // 2. wrap with trigger
    trig_en = 1'b1; trig_pc = 32'h3020;
    do_arm();
    for (int k = 0; k < 12; k++) begin
      set_ev(32'h3000 + 32'(4 * k));
      tick();
      if (k == 8)  check("trig->POST", 64'(state_o[0]), 64'd2);
      if (k == 10) check("post not done", 64'(done_o[0]), 64'd0);
    end
    ev_valid = 1'b0;
    check("wrap done", 64'(state_o[0]), 64'd3);
    check("wrap count", 64'(count_o[0]), 64'd8);
    check("wrap overflow", 64'(overflow_o[0]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wrap pop%0d pc", i), 64'(rd_pc_o[0]), 64'(32'h3010 + 32'(4 * i)));
      pop();
    end
    check("wrap drained", 64'(rd_valid_o[0]), 64'd0);
    pop();
    check("pop empty state", 64'(state_o[0]), 64'd3);

    // 3. watchdog
    trig_en = 1'b0;
    do_arm();
    set_ev(32'h4000); tick();
    set_ev(32'h4004); tick();
    ev_valid = 1'b0;
    idle(TIMEOUT - 1);
    check("wd not yet", 64'(done_o[0]), 64'd0);
    idle(1);
    check("wd done", 64'(done_o[0]), 64'd1);
    check("wd timeout", 64'(timeout_o[0]), 64'd1);
    check("wd count", 64'(count_o[0]), 64'd2);
    check("wd overflow", 64'(overflow_o[0]), 64'd0);
    check("wd pop0", 64'(rd_pc_o[0]), 64'h4000);
    pop();
    check("wd pop1", 64'(rd_pc_o[0]), 64'h4004);
    pop();
    check("wd empty", 64'(rd_valid_o[0]), 64'd0);

    // 4. arm wins over rd_en
    do_arm();
    for (int k = 0; k < 5; k++) send(32'h4100 + 32'(4 * k));
    idle(TIMEOUT);
    check("pre-arm count", 64'(count_o[0]), 64'd5);
    arm = 1'b1; rd_en = 1'b1;
    tick();
    arm = 1'b0; rd_en = 1'b0;
    check("armpri state", 64'(state_o[0]), 64'd1);
    check("armpri count", 64'(count_o[0]), 64'd0);
    check("armpri timeout", 64'(timeout_o[0]), 64'd0);
    check("armpri rd_valid", 64'(rd_valid_o[0]), 64'd0);

    // 5. trigger gating and mid-capture reset
    trig_pc = 32'h5000; trig_en = 1'b0;
    send(32'h5000);
    check("gated stays ARMED", 64'(state_o[0]), 64'd1);
    trig_en = 1'b1;
    send(32'h5000);
    check("ungated POST", 64'(state_o[0]), 64'd2);
    send(32'h5004);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst state", 64'(state_o[0]), 64'd0);
    check("midrst count", 64'(count_o[0]), 64'd0);
    send(32'h5008);
    send(32'h500C);
    check("post-rst ignored", 64'(count_o[0]), 64'd0);

    // 6. POST_TRIG=0 instance
    trig_pc = 32'h6008;
    do_arm();
    send(32'h6000);
    send(32'h6004);
    send(32'h6008);
    check("pt0 done", 64'(state_o[1]), 64'd3);
    check("pt0 count", 64'(count_o[1]), 64'd3);
    pop();
    pop();
    check("pt0 trig pc", 64'(rd_pc_o[1]), 64'h6008);
    pop();
    idle(2);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
